// File: rtl/mem_bank_xfer_ctrl_pkg.sv
// Shared geometry, derived widths and FSM encoding for the bank transfer controller.
package mem_bank_xfer_ctrl_pkg;

  localparam int unsigned SUBBANKS_PER_BANK = 8;
  localparam int unsigned COEFF_BITS        = 50;
  localparam int unsigned COEFFS_PER_BLOCK  = 8;
  localparam int unsigned LINE_WIDTH        = COEFF_BITS * COEFFS_PER_BLOCK;
  localparam int unsigned DEPTH_PER_SUBBANK = 1024;
  localparam int unsigned LEN_W             = 16;

  localparam int unsigned AAW = $clog2(DEPTH_PER_SUBBANK);
  localparam int unsigned SBW = $clog2(SUBBANKS_PER_BANK);
  localparam int unsigned GAW = SBW + AAW;

  localparam int unsigned RD_LAT_DEF     = 2;
  localparam int unsigned RESP_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_FIN   = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/mem_bank_xfer_ctrl_if.sv
// Command, line-stream and flattened bank buses between initiator side and controller.
interface mem_bank_xfer_ctrl_if;
  import mem_bank_xfer_ctrl_pkg::*;

  logic                                    cmd_valid;
  logic                                    cmd_ready;
  logic                                    cmd_wr;
  logic [GAW-1:0]                          cmd_addr;
  logic [LEN_W-1:0]                        cmd_len;
  logic                                    wr_valid;
  logic                                    wr_ready;
  logic [LINE_WIDTH-1:0]                   wr_data;
  logic                                    rd_valid;
  logic                                    rd_ready;
  logic [LINE_WIDTH-1:0]                   rd_data;
  logic                                    busy;
  logic                                    done;
  logic [SUBBANKS_PER_BANK-1:0]            we_bus;
  logic [SUBBANKS_PER_BANK*LINE_WIDTH-1:0] wdata_bus;
  logic [SUBBANKS_PER_BANK*AAW-1:0]        waddr_bus;
  logic [SUBBANKS_PER_BANK-1:0]            re_bus;
  logic [SUBBANKS_PER_BANK*AAW-1:0]        raddr_bus;
  logic [SUBBANKS_PER_BANK*LINE_WIDTH-1:0] rdata_bus;

  // Initiator plus bank model side
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, rdata_bus,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           we_bus, wdata_bus, waddr_bus, re_bus, raddr_bus
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, rdata_bus,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           we_bus, wdata_bus, waddr_bus, re_bus, raddr_bus
  );

endinterface

// File: rtl/mem_bank_xfer_ctrl_resp_fifo.sv
// Synchronous first-word-fall-through FIFO holding read responses; exposes its fill level.
module mem_xfer_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic                           valid_o,
  output logic [WIDTH-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Pointer advance with wrap for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mem_bank_xfer_ctrl.sv
// Turns block-transfer commands into per-sub-bank strobes and line streams with read credits.
module mem_bank_xfer_ctrl
  import mem_bank_xfer_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bank_xfer_ctrl_if.slave  xfer
);

  localparam int unsigned SB   = SUBBANKS_PER_BANK;
  localparam int unsigned CNTW = $clog2(RESP_DEPTH + 1);

  xfer_state_e                state_q, state_d;
  logic [GAW-1:0]             addr_q, addr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           iss_q, iss_d;
  logic [LEN_W-1:0]           xfer_cnt_q, xfer_cnt_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       wr_ready_q, wr_ready_d;
  logic [SB-1:0]              we_q, we_d;
  logic [SB-1:0]              re_q, re_d;
  logic [SB*LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SB*AAW-1:0]          waddr_q, waddr_d;
  logic [SB*AAW-1:0]          raddr_q, raddr_d;
  logic [CNTW-1:0]            inflight_q, inflight_d;
  logic [RD_LAT-1:0]          lat_vld_q;
  logic [RD_LAT-1:0][SBW-1:0] lat_id_q;

  logic                       cmd_fire;
  logic                       wr_fire;
  logic                       rd_fire;
  logic                       issue;
  logic                       cap_vld;
  logic [SBW-1:0]             cap_id;
  logic [LINE_WIDTH-1:0]      cap_data;
  logic [CNTW:0]              credit_used;
  logic                       fifo_valid;
  logic [LINE_WIDTH-1:0]      fifo_head;
  logic [CNTW-1:0]            fifo_cnt;

  assign cmd_fire    = xfer.cmd_valid & cmd_ready_q;
  assign wr_fire     = xfer.wr_valid & wr_ready_q;
  assign rd_fire     = fifo_valid & xfer.rd_ready;
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign issue       = (state_q == ST_READ) && (iss_q != len_q) &&
                       (credit_used < (CNTW+1)'(RESP_DEPTH));

  // The tag pipeline is launched together with re, so its tail lines up with the bank's rdata
  assign cap_vld  = lat_vld_q[RD_LAT-1];
  assign cap_id   = lat_id_q[RD_LAT-1];
  assign cap_data = xfer.rdata_bus[32'(cap_id)*LINE_WIDTH +: LINE_WIDTH];

  // Next-state, strobe and bus payload decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    iss_d      = iss_q;
    xfer_cnt_d = xfer_cnt_q;
    we_d       = '0;
    re_d       = '0;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    inflight_d = inflight_q + CNTW'(issue) - CNTW'(cap_vld);

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d     = xfer.cmd_addr;
          len_d      = xfer.cmd_len;
          iss_d      = '0;
          xfer_cnt_d = '0;
          if (xfer.cmd_len == '0) state_d = ST_FIN;
          else if (xfer.cmd_wr)   state_d = ST_WRITE;
          else                    state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          // Every slice carries the same payload; only the one-hot we matters to the bank
          we_d       = SB'(1) << addr_q[SBW-1:0];
          wdata_d    = {SB{xfer.wr_data}};
          waddr_d    = {SB{addr_q[GAW-1:SBW]}};
          addr_d     = addr_q + GAW'(1);
          xfer_cnt_d = xfer_cnt_q + LEN_W'(1);
          if (xfer_cnt_q + LEN_W'(1) == len_q) state_d = ST_FIN;
        end
      end
      ST_READ: begin
        if (issue) begin
          re_d    = SB'(1) << addr_q[SBW-1:0];
          raddr_d = {SB{addr_q[GAW-1:SBW]}};
          addr_d  = addr_q + GAW'(1);
          iss_d   = iss_q + LEN_W'(1);
        end
        if (rd_fire) begin
          xfer_cnt_d = xfer_cnt_q + LEN_W'(1);
          if (xfer_cnt_q + LEN_W'(1) == len_q) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
    wr_ready_d  = (state_d == ST_WRITE);
  end

  // State, registered outputs and read-tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      iss_q       <= '0;
      xfer_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      we_q        <= '0;
      re_q        <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      inflight_q  <= '0;
      lat_vld_q   <= '0;
      lat_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      iss_q       <= iss_d;
      xfer_cnt_q  <= xfer_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ready_q  <= wr_ready_d;
      we_q        <= we_d;
      re_q        <= re_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      inflight_q  <= inflight_d;
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        lat_vld_q[i] <= lat_vld_q[i-1];
        lat_id_q[i]  <= lat_id_q[i-1];
      end
      lat_vld_q[0] <= issue;
      lat_id_q[0]  <= addr_q[SBW-1:0];
    end
  end

  mem_xfer_resp_fifo #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cap_vld),
    .push_data_i (cap_data),
    .pop_i       (rd_fire),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  assign xfer.cmd_ready = cmd_ready_q;
  assign xfer.wr_ready  = wr_ready_q;
  assign xfer.rd_valid  = fifo_valid;
  assign xfer.rd_data   = fifo_head;
  assign xfer.busy      = busy_q;
  assign xfer.done      = done_q;
  assign xfer.we_bus    = we_q;
  assign xfer.wdata_bus = wdata_q;
  assign xfer.waddr_bus = waddr_q;
  assign xfer.re_bus    = re_q;
  assign xfer.raddr_bus = raddr_q;

endmodule

// File: tb/tb_mem_bank_xfer_ctrl.sv
// Directed bench: bank model is a one-register synchronous RAM per sub-bank.
module tb_mem_bank_xfer_ctrl;
  import mem_bank_xfer_ctrl_pkg::*;

  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned RESP_DEPTH = 4;
  localparam int unsigned LW         = LINE_WIDTH;
  localparam int unsigned SB         = SUBBANKS_PER_BANK;
  localparam int unsigned GDEPTH     = SUBBANKS_PER_BANK * DEPTH_PER_SUBBANK;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  mem_bank_xfer_ctrl_if bus_if ();

  mem_bank_xfer_ctrl #(
    .RD_LAT     (RD_LAT),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .xfer  (bus_if.slave)
  );

  function automatic logic [LW-1:0] pat(input int unsigned g);
    return LW'({13{32'hBEEF_0000 ^ 32'(g)}});
  endfunction

  function automatic logic [LW-1:0] dline(input int k);
    return LW'({13{32'hD00D_0000 + 32'(k)}});
  endfunction

  // Bank model: preload with pat(g), then write on we, read data one cycle after re
  logic [LW-1:0] bank_mem [SB][DEPTH_PER_SUBBANK];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int s = 0; s < int'(SB); s++)
        for (int r = 0; r < int'(DEPTH_PER_SUBBANK); r++)
          bank_mem[s][r] <= pat(32'(r) * SB + 32'(s));
      mem_init <= 1'b1;
    end else begin
      for (int s = 0; s < int'(SB); s++) begin
        if (bus_if.we_bus[s])
          bank_mem[s][bus_if.waddr_bus[s*AAW +: AAW]] <= bus_if.wdata_bus[s*LW +: LW];
        if (bus_if.re_bus[s])
          bus_if.rdata_bus[s*LW +: LW] <= bank_mem[s][bus_if.raddr_bus[s*AAW +: AAW]];
      end
    end
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("we_re_exclusive", LW'((|bus_if.we_bus) & (|bus_if.re_bus)), LW'(0));
  endtask

  task automatic do_write(input int unsigned addr, input int unsigned len, input int k0,
                          input string tg);
    int unsigned g;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = 1'b1;
    bus_if.cmd_addr  = GAW'(addr);
    bus_if.cmd_len   = LEN_W'(len);
    tick();
    bus_if.cmd_valid = 1'b0;
    chk({tg, "_busy"}, LW'(bus_if.busy), LW'(1));
    chk({tg, "_wr_ready"}, LW'(bus_if.wr_ready), LW'(1));
    chk({tg, "_cmd_ready_low"}, LW'(bus_if.cmd_ready), LW'(0));
    bus_if.wr_valid = 1'b1;
    for (int i = 0; i < int'(len); i++) begin
      bus_if.wr_data = dline(k0 + i);
      tick();
      g = (addr + 32'(i)) % GDEPTH;
      chk({tg, "_we"}, LW'(bus_if.we_bus), LW'(1) << (g % SB));
      chk({tg, "_waddr"}, LW'(bus_if.waddr_bus[(g % SB)*AAW +: AAW]), LW'(g / SB));
      chk({tg, "_wdata"}, bus_if.wdata_bus[(g % SB)*LW +: LW], dline(k0 + i));
      chk({tg, "_done_with_strobe"}, LW'(bus_if.done), LW'(i == int'(len) - 1));
    end
    bus_if.wr_valid = 1'b0;
    bus_if.wr_data  = '0;
    tick();
    chk({tg, "_done_end"}, LW'(bus_if.done), LW'(0));
    chk({tg, "_cmd_ready_back"}, LW'(bus_if.cmd_ready), LW'(1));
    chk({tg, "_we_idle"}, LW'(bus_if.we_bus), LW'(0));
  endtask

  // Follow a read from the cycle after accept until done; expects rd_ready already set
  task automatic collect(input int unsigned addr, input int unsigned len, input bit use_pat,
                         input int k0, input int nre0, input string tg,
                         output int first_re, output int first_vld);
    int          nre      = nre0;
    int          npop     = 0;
    int          last_pop = -10;
    bit          got_done = 1'b0;
    int unsigned g;
    first_re  = -1;
    first_vld = -1;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (bus_if.re_bus != '0) begin
        g = (addr + 32'(nre)) % GDEPTH;
        chk({tg, "_re"}, LW'(bus_if.re_bus), LW'(1) << (g % SB));
        chk({tg, "_raddr"}, LW'(bus_if.raddr_bus[(g % SB)*AAW +: AAW]), LW'(g / SB));
        if (first_re < 0) first_re = cyc;
        nre++;
      end
      if (bus_if.rd_valid && bus_if.rd_ready) begin
        g = (addr + 32'(npop)) % GDEPTH;
        chk({tg, "_rd_data"}, bus_if.rd_data, use_pat ? pat(g) : dline(k0 + npop));
        if (first_vld < 0) first_vld = cyc;
        last_pop = cyc;
        npop++;
      end
      if (bus_if.done) begin
        got_done = 1'b1;
        chk({tg, "_pops_at_done"}, LW'(npop), LW'(len));
        chk({tg, "_done_after_last_pop"}, LW'(cyc - last_pop), LW'(1));
        chk({tg, "_busy_at_done"}, LW'(bus_if.busy), LW'(1));
      end else begin
        tick();
      end
    end
    chk({tg, "_done_seen"}, LW'(got_done), LW'(1));
    chk({tg, "_re_total"}, LW'(nre), LW'(len));
    tick();
    chk({tg, "_cmd_ready_back"}, LW'(bus_if.cmd_ready), LW'(1));
    chk({tg, "_done_end"}, LW'(bus_if.done), LW'(0));
    chk({tg, "_rd_valid_end"}, LW'(bus_if.rd_valid), LW'(0));
  endtask

  task automatic start_read(input int unsigned addr, input int unsigned len);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = GAW'(addr);
    bus_if.cmd_len   = LEN_W'(len);
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fv, nre;
    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.wr_valid  = 1'b0;
    bus_if.wr_data   = '0;
    bus_if.rd_ready  = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", LW'(bus_if.cmd_ready), LW'(0));
    chk("rst_busy", LW'(bus_if.busy), LW'(0));
    chk("rst_done", LW'(bus_if.done), LW'(0));
    chk("rst_we", LW'(bus_if.we_bus), LW'(0));
    chk("rst_re", LW'(bus_if.re_bus), LW'(0));
    chk("rst_rd_valid", LW'(bus_if.rd_valid), LW'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", LW'(bus_if.cmd_ready), LW'(1));
    chk("idle_busy", LW'(bus_if.busy), LW'(0));

    // Four-line write starting mid-bank: sub-banks 5,6,7,0 rows 0,0,0,1
    do_write(5, 4, 0, "wr4");

    // Read the same lines back, unstalled
    bus_if.rd_ready = 1'b1;
    start_read(5, 4);
    collect(5, 4, 1'b0, 0, 0, "rd4", fr, fv);
    chk("rd4_first_valid_latency", LW'(fv - fr), LW'(RD_LAT));

    // Stalled read: credits cap issue at RESP_DEPTH
    bus_if.rd_ready = 1'b0;
    start_read(100, 10);
    nre = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.re_bus != '0) nre++;
      tick();
    end
    chk("stall_re_count", LW'(nre), LW'(RESP_DEPTH));
    chk("stall_rd_valid", LW'(bus_if.rd_valid), LW'(1));
    chk("stall_head", bus_if.rd_data, pat(100));
    bus_if.rd_ready = 1'b1;
    collect(100, 10, 1'b1, 0, int'(RESP_DEPTH), "rd10", fr, fv);

    // Address wrap at the top of the bank
    do_write(8191, 2, 10, "wrap");

    // Zero-length command
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = GAW'(0);
    bus_if.cmd_len   = '0;
    chk("len0_done_at_accept", LW'(bus_if.done), LW'(0));
    tick();
    bus_if.cmd_valid = 1'b0;
    chk("len0_done", LW'(bus_if.done), LW'(1));
    chk("len0_busy", LW'(bus_if.busy), LW'(1));
    chk("len0_cmd_ready_low", LW'(bus_if.cmd_ready), LW'(0));
    chk("len0_no_strobe", LW'(bus_if.we_bus | bus_if.re_bus), LW'(0));
    tick();
    chk("len0_done_clear", LW'(bus_if.done), LW'(0));
    chk("len0_cmd_ready_back", LW'(bus_if.cmd_ready), LW'(1));
    chk("len0_busy_clear", LW'(bus_if.busy), LW'(0));

    // Reset in the middle of a read with lines in flight
    bus_if.rd_ready = 1'b0;
    start_read(200, 8);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_ready", LW'(bus_if.cmd_ready), LW'(0));
    chk("midrst_busy", LW'(bus_if.busy), LW'(0));
    chk("midrst_done", LW'(bus_if.done), LW'(0));
    chk("midrst_wr_ready", LW'(bus_if.wr_ready), LW'(0));
    chk("midrst_rd_valid", LW'(bus_if.rd_valid), LW'(0));
    chk("midrst_rd_data", bus_if.rd_data, LW'(0));
    chk("midrst_we", LW'(bus_if.we_bus), LW'(0));
    chk("midrst_re", LW'(bus_if.re_bus), LW'(0));
    chk("midrst_raddr", LW'(bus_if.raddr_bus), LW'(0));
    chk("midrst_waddr", LW'(bus_if.waddr_bus), LW'(0));
    chk("midrst_wdata", LW'(|bus_if.wdata_bus), LW'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_rd_valid", LW'(bus_if.rd_valid), LW'(0));
      chk("postrst_done", LW'(bus_if.done), LW'(0));
    end
    bus_if.rd_ready = 1'b1;
    start_read(5, 2);
    collect(5, 2, 1'b0, 0, 0, "postrst_rd2", fr, fv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
